mem_access_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, directly downstream of the EX/MEM pipeline register. It drives the data-memory port from the EX/MEM outputs using a req/ack handshake, with byte/halfword/word lane steering, load alignment with sign or zero extension, a stall for wait-stated memory, a watchdog timeout, and a misalignment trap. It also contains the MEM/WB pipeline register that feeds write-back.

---
 rtl/cpu_mem_pkg.sv | 24 ++
 rtl/load_align.sv | 38 +++
 rtl/mem_access_stage.sv | 144 ++++++++++++++
 tb/tb_mem_access_stage.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_pkg
// Description : Shared encodings for the memory-access stage: access sizes,
//               FSM states and write-back control bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2
  } mem_state_t;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Extracts the addressed byte/halfword lane from a read word
//               and sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
  import cpu_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (addr)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_BYTE: data = {{24{sign & w_byte[7]}}, w_byte};
      SZ_HALF: data = {{16{sign & w_half[15]}}, w_half};
      default: data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Pipeline MEM stage: data-memory req/ack port with lane
//               steering, wait-state stall, watchdog abort, misalignment
//               trap and the MEM/WB pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
  import cpu_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  wb_in,
  input  logic        we_in,
  input  logic        re_in,
  input  logic [1:0]  size_in,
  input  logic        sign_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] wdata_in,
  input  logic [4:0]  rd_addr_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [1:0]  wb_out,
  output logic [31:0] rdata_wb,
  output logic [31:0] alu_wb,
  output logic [4:0]  rd_addr_wb,
  output logic        misalign,
  output logic        bus_err
);

  // The IDLE cycle counts as the first stall cycle, so WAIT gives up one early.
  localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 2);
  localparam bit         c_TO_ONE   = (TIMEOUT == 1);

  mem_state_t  r_state;
  mem_state_t  w_state_nxt;
  logic [7:0]  r_cnt;
  logic        w_mem_op;
  logic        w_is_load;
  logic        w_aligned;
  logic        w_pending;
  logic        w_timeout;
  logic [31:0] w_load_data;

  assign w_mem_op  = we_in | re_in;
  assign w_is_load = re_in & ~we_in;

  always_comb begin
    case (size_in)
      SZ_BYTE: w_aligned = 1'b1;
      SZ_HALF: w_aligned = ~alu_in[0];
      default: w_aligned = (alu_in[1:0] == 2'b00);
    endcase
  end

  assign w_pending = w_mem_op & w_aligned & (r_state != ST_ABORT);
  assign w_timeout = (r_state == ST_WAIT) ? (r_cnt == c_CNT_LAST) : c_TO_ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (r_state == ST_WAIT) ? r_cnt + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:
        if (w_pending && !dmem_ack) w_state_nxt = w_timeout ? ST_ABORT : ST_WAIT;
      ST_WAIT:
        if (!w_pending || dmem_ack) w_state_nxt = ST_IDLE;
        else if (w_timeout)         w_state_nxt = ST_ABORT;
      default:
        w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_stall = w_pending & ~dmem_ack;
    dmem_req  = w_pending & reset;
    dmem_we   = dmem_req & we_in;
    dmem_addr = {alu_in[31:2], 2'b00};
    case (size_in)
      SZ_BYTE: begin
        dmem_be    = 4'b0001 << alu_in[1:0];
        dmem_wdata = {4{wdata_in[7:0]}};
      end
      SZ_HALF: begin
        dmem_be    = 4'b0011 << {alu_in[1], 1'b0};
        dmem_wdata = {2{wdata_in[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = wdata_in;
      end
    endcase
  end

  load_align u_load_align (
    .rdata (dmem_rdata),
    .addr  (alu_in[1:0]),
    .size  (size_in),
    .sign  (sign_in),
    .data  (w_load_data)
  );

  // MEM/WB register; bubbles clear only the control field.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_out     <= '0;
      rdata_wb   <= '0;
      alu_wb     <= '0;
      rd_addr_wb <= '0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      misalign <= w_mem_op & ~w_aligned & (r_state != ST_ABORT);
      bus_err  <= (w_state_nxt == ST_ABORT);
      if (mem_stall || (r_state == ST_ABORT) || (w_mem_op && !w_aligned)) begin
        wb_out <= '0;
      end else begin
        wb_out     <= wb_in;
        rdata_wb   <= w_is_load ? w_load_data : 32'd0;
        alu_wb     <= alu_in;
        rd_addr_wb <= rd_addr_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Scoreboard bench for mem_access_stage with randomized
//               accesses, a reference model and a memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wb_in;
  logic        we_in, re_in, sign_in;
  logic [1:0]  size_in;
  logic [31:0] alu_in, wdata_in, dmem_rdata;
  logic [4:0]  rd_addr_in;
  logic        dmem_req, dmem_we, dmem_ack, mem_stall, misalign, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, rdata_wb, alu_wb;
  logic [3:0]  dmem_be;
  logic [1:0]  wb_out;
  logic [4:0]  rd_addr_wb;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .wb_in(wb_in), .we_in(we_in), .re_in(re_in),
    .size_in(size_in), .sign_in(sign_in), .alu_in(alu_in), .wdata_in(wdata_in),
    .rd_addr_in(rd_addr_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .wb_out(wb_out), .rdata_wb(rdata_wb), .alu_wb(alu_wb),
    .rd_addr_wb(rd_addr_wb), .misalign(misalign), .bus_err(bus_err)
  );

  typedef struct {
    int          due;
    logic        req, stall, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    bit          chk_wd;
  } comb_t;

  typedef struct {
    int          due;
    logic [1:0]  wb;
    logic [31:0] rdata, alu;
    logic [4:0]  rd;
    logic        mis, berr;
    bit          chk_rd;
  } reg_t;

  comb_t qc[$];
  reg_t  qr[$];
  comb_t ce;
  reg_t  re;
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;

  // Model of the MEM/WB fields that a bubble leaves untouched
  logic [31:0] sh_rdata = '0, sh_alu = '0;
  logic [4:0]  sh_rd = '0;
  bit          sh_known = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (qc.size() > 0 && qc[0].due == cyc) begin
      ce = qc.pop_front();
      chk("dmem_req", dmem_req, ce.req);
      chk("mem_stall", mem_stall, ce.stall);
      if (ce.req) begin
        chk("dmem_we", dmem_we, ce.we);
        chk("dmem_addr", dmem_addr, ce.addr);
        chk("dmem_be", dmem_be, ce.be);
        if (ce.chk_wd) chk("dmem_wdata", dmem_wdata, ce.wdata);
      end
    end
  end

  always @(posedge clk) begin
    #3;
    if (qr.size() > 0 && qr[0].due == cyc) begin
      re = qr.pop_front();
      chk("wb_out", wb_out, re.wb);
      chk("alu_wb", alu_wb, re.alu);
      chk("rd_addr_wb", rd_addr_wb, re.rd);
      chk("misalign", misalign, re.mis);
      chk("bus_err", bus_err, re.berr);
      if (re.chk_rd) chk("rdata_wb", rdata_wb, re.rdata);
    end
  end

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit al_ok(input logic [1:0] sz, input logic [31:0] a);
    return (a % nbytes(sz)) == 0;
  endfunction

  function automatic int lane_off(input logic [1:0] sz, input logic [31:0] a);
    return (nbytes(sz) == 4) ? 0 : ((a % 4) / nbytes(sz)) * nbytes(sz);
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] m = 4'((1 << nbytes(sz)) - 1);
    return m << lane_off(sz, a);
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] w);
    if (nbytes(sz) == 1) return (w & 32'hFF) * 32'h0101_0101;
    if (nbytes(sz) == 2) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic [31:0] a,
                                           input logic sg, input logic [31:0] rd);
    int          nb = nbytes(sz);
    logic [31:0] mask, v;
    if (nb == 4) return rd;
    mask = (32'h1 << (8 * nb)) - 32'h1;
    v = (rd >> (8 * lane_off(sz, a))) & mask;
    if (sg && v[8 * nb - 1]) v = v | ~mask;
    return v;
  endfunction

  // One EX/MEM instruction, held for as many cycles as the memory takes.
  // nwait >= TO means the memory never acknowledges.
  task automatic run_txn(input logic we, input logic re_, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdv,
                         input logic [4:0] rd, input logic [1:0] wb, input int nwait);
    bit    mem = we | re_;
    bit    ok  = al_ok(sz, a);
    bit    ld  = re_ & ~we;
    bit    tmo = (nwait >= TO);
    int    last = tmo ? TO : nwait;
    comb_t c;
    reg_t  r;
    we_in = we; re_in = re_; size_in = sz; sign_in = sg; alu_in = a;
    wdata_in = wd; rd_addr_in = rd; wb_in = wb;
    if (!mem || !ok) begin
      dmem_ack = 1'b0; dmem_rdata = $urandom;
      c.due = cyc; c.req = 1'b0; c.stall = 1'b0; c.we = 1'b0;
      c.addr = '0; c.be = '0; c.wdata = '0; c.chk_wd = 1'b0;
      if (!mem) begin
        sh_alu = a; sh_rd = rd; sh_rdata = '0; sh_known = 1'b1;
      end
      r.due = cyc + 1; r.wb = mem ? 2'b00 : wb; r.rdata = sh_rdata; r.alu = sh_alu;
      r.rd = sh_rd; r.mis = mem; r.berr = 1'b0; r.chk_rd = sh_known;
      qc.push_back(c); qr.push_back(r);
      @(posedge clk); #1;
    end else begin
      for (int k = 0; k <= last; k++) begin
        bit ab  = tmo && (k == TO);
        bit ack = !tmo && (k == nwait);
        dmem_ack = ack;
        dmem_rdata = ack ? rdv : $urandom;
        c.due = cyc; c.req = !ab; c.stall = !ab && !ack; c.we = we;
        c.addr = a & ~32'h3; c.be = exp_be(sz, a); c.wdata = exp_wd(sz, wd); c.chk_wd = we;
        if (ack) begin
          sh_alu = a; sh_rd = rd;
          sh_known = ld;
          if (ld) sh_rdata = exp_load(sz, a, sg, rdv);
        end
        r.due = cyc + 1; r.wb = ack ? wb : 2'b00; r.rdata = sh_rdata; r.alu = sh_alu;
        r.rd = sh_rd; r.mis = 1'b0; r.berr = tmo && (k == TO - 1); r.chk_rd = sh_known;
        qc.push_back(c); qr.push_back(r);
        @(posedge clk); #1;
      end
    end
    dmem_ack = 1'b0;
  endtask

  logic        r_we, r_re, r_sg;
  logic [1:0]  r_sz, r_v, r_wb;
  logic [31:0] r_a;
  int          r_nw;

  initial begin
    reset = 1'b0; wb_in = '0; we_in = 1'b0; re_in = 1'b1; size_in = 2'b10; sign_in = 1'b0;
    alu_in = 32'h100; wdata_in = '0; rd_addr_in = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_wb_out", wb_out, 0);
    chk("rst_rdata_wb", rdata_wb, 0);
    chk("rst_alu_wb", alu_wb, 0);
    chk("rst_rd_addr_wb", rd_addr_wb, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_bus_err", bus_err, 0);
    reset = 1'b1;

    run_txn(1, 0, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0, 5'd5, 2'b10, 0);
    run_txn(0, 1, 2'b00, 1, 32'h103, 32'h0, 32'h80112233, 5'd6, 2'b11, 0);
    run_txn(0, 1, 2'b00, 0, 32'h103, 32'h0, 32'h80112233, 5'd7, 2'b11, 0);
    run_txn(1, 0, 2'b01, 0, 32'h102, 32'h0000ABCD, 32'h0, 5'd8, 2'b00, 3);
    run_txn(0, 1, 2'b10, 0, 32'h101, 32'h0, 32'h12345678, 5'd9, 2'b11, 0);
    run_txn(0, 1, 2'b10, 0, 32'h200, 32'h0, 32'h0, 5'd10, 2'b11, TO);
    run_txn(1, 1, 2'b01, 1, 32'h206, 32'h1234F00D, 32'hFFFFFFFF, 5'd11, 2'b10, 1);
    run_txn(0, 0, 2'b10, 0, 32'h0BADF00D, 32'h0, 32'h0, 5'd12, 2'b10, 0);
    run_txn(0, 1, 2'b01, 1, 32'h302, 32'h0, 32'h9ABC0000, 5'd13, 2'b11, 2);
    run_txn(0, 1, 2'b11, 0, 32'h304, 32'h0, 32'hCAFEBABE, 5'd14, 2'b11, 0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        r_we = 1'b0; r_re = 1'b0;
      end else begin
        r_v = 2'($urandom_range(1, 3));
        r_we = r_v[1]; r_re = r_v[0];
      end
      r_sz = 2'($urandom_range(0, 3));
      r_sg = 1'($urandom_range(0, 1));
      r_wb = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      if ($urandom_range(0, 9) < 7) r_a[1:0] = 2'b00;
      r_nw = ($urandom_range(0, 9) == 0) ? TO + 1 : $urandom_range(0, TO - 1);
      run_txn(r_we, r_re, r_sz, r_sg, r_a, $urandom, $urandom, 5'($urandom), r_wb, r_nw);
    end

    we_in = 1'b0; re_in = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    chk("queue_drained", qc.size() + qr.size(), 0);

    // Reset in the middle of a wait-stated load
    re_in = 1'b1; size_in = 2'b10; alu_in = 32'h300; wb_in = 2'b11; rd_addr_in = 5'd4;
    @(posedge clk); #1;
    chk("wait_dmem_req", dmem_req, 1);
    chk("wait_mem_stall", mem_stall, 1);
    #3 reset = 1'b0;
    #1;
    chk("midrst_dmem_req", dmem_req, 0);
    chk("midrst_wb_out", wb_out, 0);
    chk("midrst_rdata_wb", rdata_wb, 0);
    chk("midrst_alu_wb", alu_wb, 0);
    chk("midrst_rd_addr_wb", rd_addr_wb, 0);
    chk("midrst_misalign", misalign, 0);
    chk("midrst_bus_err", bus_err, 0);
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    chk("lateack_dmem_req", dmem_req, 0);
    chk("lateack_wb_out", wb_out, 0);
    chk("lateack_alu_wb", alu_wb, 0);
    reset = 1'b1; re_in = 1'b0; wb_in = 2'b01; alu_in = 32'h55; rd_addr_in = 5'd3;
    @(posedge clk); #1;
    chk("post_dmem_req", dmem_req, 0);
    chk("post_mem_stall", mem_stall, 0);
    chk("post_bus_err", bus_err, 0);
    chk("post_wb_out", wb_out, 2'b01);
    chk("post_alu_wb", alu_wb, 32'h55);
    chk("post_rdata_wb", rdata_wb, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
